// File: rtl/sf_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sf_counter_pkg
// Purpose  : Constants and types shared by the pulse counter and pulse_stats.
// Revision : 1.0
// ============================================================================
package sf_counter_pkg;

  localparam int SF_DATA_W       = 32;
  localparam int SF_WIN_LOG2_DEF = 4;
  localparam int SF_OVR_W        = 16;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  function automatic logic [SF_OVR_W-1:0] sat_inc(input logic [SF_OVR_W-1:0] v);
    return (v == {SF_OVR_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage : sf_counter_pkg
`default_nettype wire

// File: rtl/pulse_stats_acc.sv
`default_nettype none
// ============================================================================
// Module   : pulse_stats_acc
// Purpose  : Window accumulator for min/max/sum/fill with completion strobe.
// Revision : 1.0
// ============================================================================
module pulse_stats_acc
  import sf_counter_pkg::*;
#(
  parameter int DATA_W   = SF_DATA_W,
  parameter int WIN_LOG2 = SF_WIN_LOG2_DEF,
  parameter int SUM_W    = DATA_W + WIN_LOG2
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic [WIN_LOG2:0] win_fill,
  output logic              done,
  output logic [DATA_W-1:0] res_min,
  output logic [DATA_W-1:0] res_max,
  output logic [SUM_W-1:0]  res_sum
);

  localparam int FILL_W = WIN_LOG2 + 1;
  localparam logic [FILL_W-1:0] LAST_FILL = FILL_W'((1 << WIN_LOG2) - 1);

  logic [DATA_W-1:0] acc_min_q, acc_min_d;
  logic [DATA_W-1:0] acc_max_q, acc_max_d;
  logic [SUM_W-1:0]  acc_sum_q, acc_sum_d;
  logic [FILL_W-1:0] fill_q, fill_d;

  logic              accept;
  logic [DATA_W-1:0] upd_min;
  logic [DATA_W-1:0] upd_max;
  logic [SUM_W-1:0]  upd_sum;

  always_comb begin
    accept  = in_valid & ~clear;
    upd_min = (in_data < acc_min_q) ? in_data : acc_min_q;
    upd_max = (in_data > acc_max_q) ? in_data : acc_max_q;
    upd_sum = acc_sum_q + SUM_W'(in_data);
    done    = accept && (fill_q == LAST_FILL);

    acc_min_d = acc_min_q;
    acc_max_d = acc_max_q;
    acc_sum_d = acc_sum_q;
    fill_d    = fill_q;

    // The completing sample is reported via upd_*, so the registers can empty now.
    if (clear || done) begin
      acc_min_d = '1;
      acc_max_d = '0;
      acc_sum_d = '0;
      fill_d    = '0;
    end else if (accept) begin
      acc_min_d = upd_min;
      acc_max_d = upd_max;
      acc_sum_d = upd_sum;
      fill_d    = fill_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      acc_min_q <= '1;
      acc_max_q <= '0;
      acc_sum_q <= '0;
      fill_q    <= '0;
    end else begin
      acc_min_q <= acc_min_d;
      acc_max_q <= acc_max_d;
      acc_sum_q <= acc_sum_d;
      fill_q    <= fill_d;
    end
  end

  assign win_fill = fill_q;
  assign res_min  = upd_min;
  assign res_max  = upd_max;
  assign res_sum  = upd_sum;

endmodule : pulse_stats_acc
`default_nettype wire

// File: rtl/pulse_stats.sv
`default_nettype none
// ============================================================================
// Module   : pulse_stats
// Purpose  : Windowed pulse-width statistics with a one-entry result register.
// Revision : 1.0
// ============================================================================
module pulse_stats
  import sf_counter_pkg::*;
#(
  parameter int DATA_W   = SF_DATA_W,
  parameter int WIN_LOG2 = SF_WIN_LOG2_DEF,
  parameter int SUM_W    = DATA_W + WIN_LOG2
) (
  input  logic                sys_clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_min,
  output logic [DATA_W-1:0]   out_max,
  output logic [SUM_W-1:0]    out_sum,
  output logic [DATA_W-1:0]   out_avg,
  output logic [SF_OVR_W-1:0] overrun_cnt,
  output logic [WIN_LOG2:0]   win_fill
);

  logic              done;
  logic [DATA_W-1:0] res_min;
  logic [DATA_W-1:0] res_max;
  logic [SUM_W-1:0]  res_sum;

  pulse_stats_acc #(
    .DATA_W   (DATA_W),
    .WIN_LOG2 (WIN_LOG2),
    .SUM_W    (SUM_W)
  ) u_acc (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .clear    (clear),
    .in_valid (in_valid),
    .in_data  (in_data),
    .win_fill (win_fill),
    .done     (done),
    .res_min  (res_min),
    .res_max  (res_max),
    .res_sum  (res_sum)
  );

  out_state_e          state_q, state_d;
  logic [DATA_W-1:0]   out_min_q, out_min_d;
  logic [DATA_W-1:0]   out_max_q, out_max_d;
  logic [SUM_W-1:0]    out_sum_q, out_sum_d;
  logic [DATA_W-1:0]   out_avg_q, out_avg_d;
  logic [SF_OVR_W-1:0] ovr_q, ovr_d;
  logic                load;

  always_comb begin
    state_d   = state_q;
    out_min_d = out_min_q;
    out_max_d = out_max_q;
    out_sum_d = out_sum_q;
    out_avg_d = out_avg_q;
    ovr_d     = ovr_q;
    load      = 1'b0;

    case (state_q)
      ST_EMPTY: begin
        if (done) begin
          load    = 1'b1;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          load    = done;
          state_d = done ? ST_FULL : ST_EMPTY;
        end else if (done) begin
          // Unconsumed result wins; the new window is dropped.
          ovr_d = sat_inc(ovr_q);
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (load) begin
      out_min_d = res_min;
      out_max_d = res_max;
      out_sum_d = res_sum;
      out_avg_d = res_sum[SUM_W-1:WIN_LOG2];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q   <= ST_EMPTY;
      out_min_q <= '0;
      out_max_q <= '0;
      out_sum_q <= '0;
      out_avg_q <= '0;
      ovr_q     <= '0;
    end else begin
      state_q   <= state_d;
      out_min_q <= out_min_d;
      out_max_q <= out_max_d;
      out_sum_q <= out_sum_d;
      out_avg_q <= out_avg_d;
      ovr_q     <= ovr_d;
    end
  end

  assign out_valid   = (state_q == ST_FULL);
  assign out_min     = out_min_q;
  assign out_max     = out_max_q;
  assign out_sum     = out_sum_q;
  assign out_avg     = out_avg_q;
  assign overrun_cnt = ovr_q;

endmodule : pulse_stats
`default_nettype wire
